// File: rtl/dmem_pkg.sv
// dmem_pkg: encodings and helpers shared by the byte-serial load/store unit.
// The misalignment helper is only referenced when DMEM_CTRL_ALIGN_CHECK_EN is set.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // index of the last byte lane touched; size 2'b11 behaves as a word
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    logic [1:0] r;
    unique case (1'b1)
      size == SIZE_B: r = 2'd0;
      size == SIZE_H: r = 2'd1;
      default:        r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic r;
    unique case (1'b1)
      size == SIZE_B: r = 1'b0;
      size == SIZE_H: r = lo[0];
      default:        r = (lo != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [7:0] byte_sel(
    input logic [31:0] d,
    input logic [1:0]  k
  );
    return d[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: sign/zero extension of assembled load lanes.
// Word loads pass through untouched regardless of the unsigned flag.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] i_lanes,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic w_sb;
  logic w_sh;

  always_comb begin
    w_sb   = i_lanes[7] & ~i_unsigned;
    w_sh   = i_lanes[15] & ~i_unsigned;
    o_data = i_lanes;
    unique case (1'b1)
      i_size == SIZE_B: o_data = {{24{w_sb}}, i_lanes[7:0]};
      i_size == SIZE_H: o_data = {{16{w_sh}}, i_lanes[15:0]};
      default:          o_data = i_lanes;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: serialises byte/half/word accesses onto a single-byte RAM port.
// Define DMEM_CTRL_ALIGN_CHECK_EN to reject misaligned half/word requests.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [1:0]        r_size;
  logic [1:0]        r_last;
  logic [1:0]        r_k;
  logic              r_write;
  logic              r_uns;
  logic              r_mem_we;
  logic [7:0]        r_mem_wdata;
  logic [31:0]       r_wdata;
  logic [31:0]       r_lanes;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [31:0]       r_rsp_rdata;

  logic [1:0]        w_knext;
  logic [31:0]       w_lanes;
  logic [31:0]       w_ext;
  logic              w_mis;
  logic              w_unused;

  assign w_knext  = r_k + 2'd1;
  assign w_unused = ^req_addr[31:ADDR_W];

`ifdef DMEM_CTRL_ALIGN_CHECK_EN
  assign w_mis = misaligned(req_size, req_addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  // final byte arrives during WAIT; merge it so RESP data is ready at once
  always_comb begin
    w_lanes = r_lanes;
    w_lanes[{r_last, 3'b000} +: 8] = mem_rdata;
  end

  dmem_load_ext u_ext (
    .i_lanes    (w_lanes),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_size      <= SIZE_B;
      r_last      <= 2'd0;
      r_k         <= 2'd0;
      r_write     <= 1'b0;
      r_uns       <= 1'b0;
      r_wdata     <= '0;
      r_lanes     <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr[ADDR_W-1:0];
            r_size  <= req_size;
            r_last  <= last_idx(req_size);
            r_write <= req_write;
            r_uns   <= req_unsigned;
            r_wdata <= req_wdata;
            r_lanes <= '0;
            r_k     <= 2'd0;
            if (w_mis) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_state     <= XFER;
              r_mem_addr  <= req_addr[ADDR_W-1:0];
              r_mem_we    <= req_write;
              r_mem_wdata <= req_wdata[7:0];
            end
          end
        end
        XFER: begin
          if (r_k != 2'd0 && !r_write) begin
            r_lanes[{r_k - 2'd1, 3'b000} +: 8] <= mem_rdata;
          end
          if (r_k == r_last) begin
            r_mem_we <= 1'b0;
            if (r_write) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end else begin
            r_k         <= w_knext;
            r_mem_addr  <= r_addr + ADDR_W'(w_knext);
            r_mem_wdata <= byte_sel(r_wdata, w_knext);
          end
        end
        WAIT: begin
          r_lanes     <= w_lanes;
          r_rsp_rdata <= w_ext;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: random and directed load/store traffic against a byte RAM.
// A per-cycle checker compares the DUT with a transaction-level model.
module tb_dmem_ctrl;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  dmem_ctrl #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [64];
  int cyc = 0;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
    cyc <= cyc + 1;
  end

  int total = 0;
  int bad = 0;

  logic [7:0]  ref_mem [64];
  bit          busy = 1'b0;
  int          t0, lat, op_n;
  logic [5:0]  op_addr;
  bit          op_wr, op_mis;
  logic [31:0] op_wd, op_rd;
  logic [31:0] last_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic plan();
    logic [31:0] v;
    t0      = cyc;
    op_wr   = req_write;
    op_addr = req_addr[5:0];
    op_wd   = req_wdata;
    op_n    = (req_size == 2'b00) ? 1 : (req_size == 2'b01) ? 2 : 4;
`ifdef DMEM_CTRL_ALIGN_CHECK_EN
    op_mis = (op_n == 2 && req_addr[0]) ||
             (op_n == 4 && req_addr[1:0] != 2'b00);
`else
    op_mis = 1'b0;
`endif
    lat = op_mis ? 1 : (op_wr ? op_n + 1 : op_n + 2);
    v = '0;
    for (int i = 0; i < op_n; i++)
      v = v | (32'(ref_mem[(int'(op_addr) + i) % 64]) << (8 * i));
    if (!req_unsigned && op_n == 1 && v[7]) v = v | 32'hFFFF_FF00;
    if (!req_unsigned && op_n == 2 && v[15]) v = v | 32'hFFFF_0000;
    op_rd = v;
    busy  = 1'b1;
  endtask

  task automatic checker_loop();
    int j;
    int a;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy    = 1'b0;
        last_rd = '0;
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
      end else begin
        j = cyc - t0;
        if (busy && j > lat) busy = 1'b0;
        if (busy) begin
          chk("busy_ready", req_ready, 0);
          chk("rsp_valid", rsp_valid, 32'(j == lat));
          chk("rsp_err", rsp_err, 32'(j == lat && op_mis));
          chk("mem_we", mem_we,
              32'(op_wr && !op_mis && j <= op_n));
          if (!op_mis && j <= op_n) begin
            a = (int'(op_addr) + j - 1) % 64;
            chk("mem_addr", 32'(mem_addr), 32'(a));
            if (op_wr) begin
              chk("mem_wdata", 32'(mem_wdata),
                  (op_wd >> (8 * (j - 1))) & 32'hFF);
              ref_mem[a] = 8'(op_wd >> (8 * (j - 1)));
            end
          end
          if (j == lat && op_mis) last_rd = '0;
          else if (j == lat && !op_wr) last_rd = op_rd;
          chk("rsp_rdata", rsp_rdata, last_rd);
        end else begin
          chk("idle_ready", req_ready, 1);
          chk("idle_valid", rsp_valid, 0);
          chk("idle_err", rsp_err, 0);
          chk("idle_we", mem_we, 0);
          chk("idle_rdata", rsp_rdata, last_rd);
          if (req_valid) plan();
        end
      end
    end
  endtask

  task automatic wait_ready(output int t);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!req_ready && g < 50);
    if (!req_ready) chk("ready_timeout", 0, 1);
    t = cyc;
  endtask

  task automatic wait_rsp(input int t, output logic [31:0] rd,
                          output int lt, output logic er);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!rsp_valid && g < 20);
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
    lt = cyc - t;
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic drive(input logic wr, input logic [1:0] sz,
                       input logic un, input logic [31:0] ad,
                       input logic [31:0] wd);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = ad;
    req_wdata    = wd;
    req_valid    = 1'b1;
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz,
                        input logic un, input logic [31:0] ad,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output int lt, output logic er);
    int t;
    @(posedge clk);
    #2;
    drive(wr, sz, un, ad, wd);
    wait_ready(t);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    wait_rsp(t, rd, lt, er);
  endtask

  initial begin
    logic [31:0] rd;
    int lt, ta, tb;
    logic er;
    fork
      checker_loop();
    join_none
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      do_req(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, rd, lt, er);

    do_req(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, rd, lt, er);
    chk("sw_lat", lt, 5);
    chk("ram8", ram[8], 8'hEF);
    chk("ram9", ram[9], 8'hBE);
    chk("ram10", ram[10], 8'hAD);
    chk("ram11", ram[11], 8'hDE);
    do_req(1'b0, 2'b10, 1'b0, 32'd8, 0, rd, lt, er);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_lat", lt, 6);
    chk("lw_err", er, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'd8, 0, rd, lt, er);
    chk("lh_data", rd, 32'hFFFFBEEF);
    chk("lh_lat", lt, 4);
    do_req(1'b0, 2'b01, 1'b1, 32'd8, 0, rd, lt, er);
    chk("lhu_data", rd, 32'h0000BEEF);
    do_req(1'b0, 2'b00, 1'b0, 32'd10, 0, rd, lt, er);
    chk("lb_data", rd, 32'hFFFFFFAD);
    chk("lb_lat", lt, 3);
    do_req(1'b0, 2'b00, 1'b1, 32'd10, 0, rd, lt, er);
    chk("lbu_data", rd, 32'h000000AD);
    do_req(1'b1, 2'b00, 1'b0, 32'h100 + 32'd12, 32'h77, rd, lt, er);
    chk("sb_lat", lt, 2);
    chk("ram12", ram[12], 8'h77);

`ifdef DMEM_CTRL_ALIGN_CHECK_EN
    do_req(1'b0, 2'b01, 1'b0, 32'd5, 0, rd, lt, er);
    chk("mis_lat", lt, 1);
    chk("mis_err", er, 1);
    chk("mis_data", rd, 0);
`else
    do_req(1'b1, 2'b10, 1'b0, 32'd62, 32'h11223344, rd, lt, er);
    chk("ram62", ram[62], 8'h44);
    chk("ram63", ram[63], 8'h33);
    chk("ram0", ram[0], 8'h22);
    chk("ram1", ram[1], 8'h11);
    do_req(1'b0, 2'b10, 1'b0, 32'd62, 0, rd, lt, er);
    chk("wrap_data", rd, 32'h11223344);
`endif

    // two requests with req_valid held continuously
    @(posedge clk);
    #2;
    drive(1'b1, 2'b10, 1'b0, 32'd20, 32'hCAFEF00D);
    wait_ready(ta);
    @(posedge clk);
    #2;
    drive(1'b0, 2'b00, 1'b0, 32'd21, 0);
    wait_ready(tb);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    wait_rsp(tb, rd, lt, er);
    chk("b2b_gap", tb - ta, 6);
    chk("b2b_data", rd, 32'hFFFFFFF0);

    // reset in the middle of a word store
    do_req(1'b1, 2'b10, 1'b0, 32'd16, 32'hA55A7E3C, rd, lt, er);
    @(posedge clk);
    #2;
    drive(1'b1, 2'b10, 1'b0, 32'd16, 32'h04030201);
    wait_ready(ta);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", req_ready, 1);
    chk("rst_ram16", ram[16], 8'h01);
    chk("rst_ram17", ram[17], 8'h02);
    chk("rst_ram18", ram[18], 8'h5A);
    chk("rst_ram19", ram[19], 8'hA5);

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_req(1'($urandom), 2'($urandom), 1'($urandom), $urandom,
             $urandom, rd, lt, er);
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 64; i++) chk("ram_final", ram[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
